shift_add_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier: WIDTH-bit operands, 2·WIDTH-bit product, selectable unsigned or two's-complement signed mode. It has an explicit start/busy/done handshake and synchronous reset. It is the successor to the fixed unsigned multiplier and sits in the datapath wherever a multi-cycle multiply is acceptable in exchange for a small area (one adder, no array).

---
 rtl/mult_pkg.sv | 14 +
 rtl/shift_add_multiplier_if.sv | 22 ++
 rtl/shift_add_multiplier_sign_conv.sv | 10 +
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_shift_add_multiplier.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Iteration counter width; WIDTH=2 still needs one bit to count 0..1.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier_sign_conv.sv
// Conditional two's-complement negate: magnitude in, negated value out when neg=1.
module sign_conv #(
  parameter int WIDTH = 4
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or signed, one iteration per clock.
// Signed operands are multiplied as magnitudes and the sign is reapplied at the end.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);
  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t                   state_reg, state_next;
  logic [WIDTH-1:0]         mcand_reg, mplier_reg;
  logic [2*WIDTH-1:0]       acc_reg, acc_next, result_signed, product_reg;
  logic [CNT_W-1:0]         count_reg;
  logic                     neg_reg, done_reg;
  logic [WIDTH:0]           sum;
  logic                     accept, finish;
  logic [1:0][WIDTH-1:0]    op_raw, op_mag;

  assign op_raw[0] = bus.a;
  assign op_raw[1] = bus.b;

  // Operand magnitudes; -2^(W-1) maps onto 2^(W-1) as an unsigned value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_op_conv
    sign_conv #(.WIDTH(WIDTH)) u_conv (
      .neg (bus.is_signed & op_raw[gi][WIDTH-1]),
      .x   (op_raw[gi]),
      .y   (op_mag[gi])
    );
  end

  // The adder keeps its carry so the shifted-in bit is never lost.
  assign sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next = {sum, acc_reg[WIDTH-1:1]};

  sign_conv #(.WIDTH(2*WIDTH)) u_conv_result (
    .neg (neg_reg),
    .x   (acc_next),
    .y   (result_signed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count_reg == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        mcand_reg  <= op_mag[0];
        mplier_reg <= op_mag[1];
        acc_reg    <= '0;
        count_reg  <= '0;
        neg_reg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end else if (state_reg == RUN) begin
        acc_reg    <= acc_next;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
      end
      if (finish) begin
        product_reg <= result_signed;
      end
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = done_reg;
  assign bus.product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed scenarios plus exhaustive/random sweeps against an arithmetic model.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(4)) bus4();
  shift_add_multiplier_if #(.WIDTH(8)) bus8();

  shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: interpret operands as integers and multiply, truncated to 2*w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint va, vb, prod;
    logic [63:0] mask;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    prod = va * vb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(prod) & mask;
  endfunction

  // One start pulse; returns product and cycles from accept edge to done (-1 on timeout).
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] p, output int lat);
    if (w == 4) begin
      bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.is_signed = s; bus4.start = 1'b1;
    end else begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.is_signed = s; bus8.start = 1'b1;
    end
    tick();
    bus4.start = 1'b0;
    bus8.start = 1'b0;
    lat = -1;
    p   = '0;
    for (int c = 1; c <= 3 * w; c++) begin
      tick();
      if ((w == 4) ? bus4.done : bus8.done) begin
        lat = c;
        p = (w == 4) ? {56'd0, bus4.product} : {48'd0, bus8.product};
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus4.start = 1'b1; bus4.a = 4'd5; bus4.b = 4'd3; bus4.is_signed = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0;
    tick();
    tick();
    checks += 4;
    if (bus4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus4.busy); end
    if (bus4.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus4.done); end
    if (bus4.product !== 8'd0) begin failures++; $display("FAIL reset_product got=%h want=00", bus4.product); end
    if (bus8.product !== 16'd0) begin failures++; $display("FAIL reset_product8 got=%h want=0000", bus8.product); end
    bus4.start = 1'b0;
    reset = 1'b0;
    tick();
    $display("reset: busy=%b done=%b product=%h", bus4.busy, bus4.done, bus4.product);
  endtask

  task automatic test_unsigned();
    logic [3:0] ta [4] = '{4'd5, 4'd15, 4'd0, 4'd5};
    logic [3:0] tb [4] = '{4'd3, 4'd15, 4'd3, 4'd0};
    logic [7:0] te [4] = '{8'd15, 8'd225, 8'd0, 8'd0};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(4, 32'(ta[i]), 32'(tb[i]), 1'b0, p, lat);
      checks += 2;
      if (p[7:0] !== te[i]) begin failures++; $display("FAIL unsigned_product %0d*%0d got=%h want=%h", ta[i], tb[i], p[7:0], te[i]); end
      if (lat !== 4) begin failures++; $display("FAIL unsigned_latency got=%0d want=4", lat); end
      tick();
      checks++;
      if (bus4.done !== 1'b0) begin failures++; $display("FAIL done_width got=%b want=0", bus4.done); end
      $display("unsigned: %0d*%0d -> %h latency=%0d", ta[i], tb[i], p[7:0], lat);
    end
  endtask

  task automatic test_signed();
    logic [3:0] ta [3] = '{4'b1101, 4'b1000, 4'b1000};
    logic [3:0] tb [3] = '{4'd5, 4'b1000, 4'd7};
    logic [7:0] te [3] = '{8'hF1, 8'h40, 8'hC8};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(4, 32'(ta[i]), 32'(tb[i]), 1'b1, p, lat);
      checks += 2;
      if (p[7:0] !== te[i]) begin failures++; $display("FAIL signed_product %h*%h got=%h want=%h", ta[i], tb[i], p[7:0], te[i]); end
      if (lat !== 4) begin failures++; $display("FAIL signed_latency got=%0d want=4", lat); end
      $display("signed: %h*%h -> %h latency=%0d", ta[i], tb[i], p[7:0], lat);
    end
  endtask

  task automatic test_busy();
    logic busy_h [13];
    logic done_h [13];
    logic [7:0] p = '0;
    int ndone = 0;
    bus4.a = 4'd2; bus4.b = 4'd3; bus4.is_signed = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    checks++;
    if (bus4.busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept got=%b want=1", bus4.busy); end
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin bus4.a = 4'd7; bus4.b = 4'd7; bus4.start = 1'b1; end
      tick();
      if (c == 2) bus4.start = 1'b0;
      busy_h[c] = bus4.busy;
      done_h[c] = bus4.done;
      if (bus4.done) begin ndone++; p = bus4.product; end
    end
    for (int c = 1; c <= 12; c++) begin
      checks += 2;
      if (busy_h[c] !== (c < 4)) begin failures++; $display("FAIL busy_window cycle=%0d got=%b want=%b", c, busy_h[c], c < 4); end
      if (done_h[c] !== (c == 4)) begin failures++; $display("FAIL busy_done cycle=%0d got=%b want=%b", c, done_h[c], c == 4); end
    end
    checks += 2;
    if (ndone !== 1) begin failures++; $display("FAIL busy_done_count got=%0d want=1", ndone); end
    if (p !== 8'd6) begin failures++; $display("FAIL busy_product got=%h want=06", p); end
    $display("busy: dones=%0d product=%h", ndone, p);
  endtask

  task automatic test_back_to_back();
    int d_cyc [2] = '{-1, -1};
    logic [7:0] d_prod [2] = '{8'd0, 8'd0};
    int n = 0;
    bus4.a = 4'd3; bus4.b = 4'd3; bus4.is_signed = 1'b0; bus4.start = 1'b1;
    tick();
    // New operands presented while busy; they must only be taken in the done cycle.
    bus4.a = 4'd4; bus4.b = 4'd4;
    for (int c = 1; c <= 16 && n < 2; c++) begin
      tick();
      if (bus4.done) begin
        d_cyc[n] = c; d_prod[n] = bus4.product; n++;
        if (n == 2) bus4.start = 1'b0;
      end
    end
    bus4.start = 1'b0;
    checks += 4;
    if (d_cyc[0] !== 4) begin failures++; $display("FAIL b2b_first_cycle got=%0d want=4", d_cyc[0]); end
    if (d_prod[0] !== 8'd9) begin failures++; $display("FAIL b2b_first_product got=%h want=09", d_prod[0]); end
    // Second accept happens on the edge ending the done cycle, then WIDTH iterations.
    if (d_cyc[1] !== 9) begin failures++; $display("FAIL b2b_second_cycle got=%0d want=9", d_cyc[1]); end
    if (d_prod[1] !== 8'd16) begin failures++; $display("FAIL b2b_second_product got=%h want=10", d_prod[1]); end
    $display("back_to_back: %h@%0d %h@%0d", d_prod[0], d_cyc[0], d_prod[1], d_cyc[1]);
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    int ndone = 0;
    bus4.a = 4'd5; bus4.b = 4'd3; bus4.is_signed = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (bus4.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", bus4.busy); end
    if (bus4.done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b want=0", bus4.done); end
    if (bus4.product !== 8'd0) begin failures++; $display("FAIL midreset_product got=%h want=00", bus4.product); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus4.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL midreset_stray_done got=%0d want=0", ndone); end
    run_op(4, 32'd2, 32'd2, 1'b0, p, lat);
    checks++;
    if (p[7:0] !== 8'd4 || lat !== 4) begin failures++; $display("FAIL midreset_followup got=%h lat=%0d want=04 lat=4", p[7:0], lat); end
    $display("reset_mid: stray_dones=%0d followup=%h", ndone, p[7:0]);
  endtask

  task automatic test_exhaustive_w4();
    logic [63:0] p, e;
    int lat;
    int bad = 0;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_op(4, 32'(a), 32'(b), s[0], p, lat);
          e = model(4, 32'(a), 32'(b), s[0]);
          checks++;
          if (p !== e || lat !== 4) begin
            failures++; bad++;
            $display("FAIL sweep4 s=%0d a=%0d b=%0d got=%h lat=%0d want=%h lat=4", s, a, b, p[7:0], lat, e[7:0]);
          end
        end
      end
      $display("sweep4: signed=%0d vectors=256 bad=%0d", s, bad);
    end
  endtask

  task automatic test_random_w8();
    logic [63:0] p, e;
    logic [31:0] a, b;
    logic s;
    int lat;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(255));
      b = 32'($urandom_range(255));
      s = 1'($urandom_range(1));
      if (i == 0) begin a = 32'h80; b = 32'h80; s = 1'b1; end
      run_op(8, a, b, s, p, lat);
      e = model(8, a, b, s);
      checks++;
      if (p !== e || lat !== 8) begin
        failures++; bad++;
        $display("FAIL random8 s=%0d a=%h b=%h got=%h lat=%0d want=%h lat=8", s, a[7:0], b[7:0], p[15:0], lat, e[15:0]);
      end
    end
    $display("random8: vectors=300 bad=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive_w4();
    test_random_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
